// File: rtl/audio_voice_scheduler.sv
// audio_voice_scheduler
//   Runs the codec INIT handshake, then on every data_over strobe reads one
//   sample per playing voice from the shared sample ROM, sums them with
//   saturation and presents the mix on LDATA/RDATA.
//
//   Optional feature macro: STEREO_PAN_EN (adds trig_pan and a per-voice pan,
//   two accumulators; when undefined LDATA and RDATA carry the same mix).
//
//   Ports:
//     Clk, Reset               clock, asynchronous active-high reset
//     INIT, INIT_FINISH        init handshake with the audio interface
//     data_over                strobe: next output sample requested
//     LDATA, RDATA             mixed signed 16-bit samples
//     trig/trig_addr/trig_len  per-voice start pulse, start address, length
//     trig_pan                 per-voice pan (STEREO_PAN_EN only)
//     busy                     per-voice playing flag
//     rom_rd/rom_addr/rom_data sample ROM port, data one cycle after rom_rd
//     ready                    init complete, mixing active
//     overrun                  sticky: data_over seen while a mix was running
module audio_voice_scheduler #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned AW         = 16,
   parameter int unsigned LW         = 16
) (
   input  logic                     Clk,
   input  logic                     Reset,
   output logic                     INIT,
   input  logic                     INIT_FINISH,
   input  logic                     data_over,
   output logic [15:0]              LDATA,
   output logic [15:0]              RDATA,
   input  logic [NUM_VOICES-1:0]    trig,
   input  logic [NUM_VOICES*AW-1:0] trig_addr,
   input  logic [NUM_VOICES*LW-1:0] trig_len,
`ifdef STEREO_PAN_EN
   input  logic [2*NUM_VOICES-1:0]  trig_pan,
`endif
   output logic [NUM_VOICES-1:0]    busy,
   output logic                     rom_rd,
   output logic [AW-1:0]            rom_addr,
   input  logic [15:0]              rom_data,
   output logic                     ready,
   output logic                     overrun
);

   localparam int unsigned V_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned ACC_W = 16 + $clog2(NUM_VOICES);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

   state_t                  r_state;
   logic                    r_init;
   logic                    r_ready;
   logic                    r_overrun;
   logic                    r_rom_rd;
   logic [AW-1:0]           r_rom_addr;
   logic [V_W-1:0]          r_v;
   logic                    r_pend;     // rom_data this cycle belongs to voice r_pend_v
   logic [V_W-1:0]          r_pend_v;
   logic [NUM_VOICES-1:0]   r_busy;
   logic [AW-1:0]           r_ptr [NUM_VOICES];
   logic [LW-1:0]           r_len [NUM_VOICES];
   logic signed [ACC_W-1:0] r_acc_l;
   logic [15:0]             r_ldata;
   logic [V_W-1:0]          w_v_nxt;
   logic signed [ACC_W-1:0] w_samp;
   logic signed [ACC_W-1:0] w_add_l;

   assign w_v_nxt = r_v + 1'b1;
   assign w_samp  = ACC_W'($signed(rom_data));

`ifdef STEREO_PAN_EN
   logic [1:0]              r_pan [NUM_VOICES];
   logic signed [ACC_W-1:0] r_acc_r;
   logic [15:0]             r_rdata;
   logic signed [ACC_W-1:0] w_add_r;

   always_comb begin
      w_add_l = w_samp;
      w_add_r = w_samp;
      case (r_pan[r_pend_v])
         2'b01:   w_add_r = '0;
         2'b10:   w_add_l = '0;
         2'b11: begin
            w_add_l = w_samp >>> 1;
            w_add_r = w_samp >>> 1;
         end
         default: ;
      endcase
   end

   assign RDATA = r_rdata;
`else
   assign w_add_l = w_samp;
   assign RDATA   = r_ldata;
`endif

   // Clamp the wide accumulator into signed 16 bits.
   function automatic logic [15:0] sat16(input logic [ACC_W-1:0] a);
      logic [ACC_W-16:0] hi;
      hi = a[ACC_W-1:15];
      if ((&hi) || !(|hi)) return a[15:0];
      else if (a[ACC_W-1]) return 16'h8000;
      else                 return 16'h7FFF;
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= S_INIT;
         r_init     <= 1'b0;
         r_ready    <= 1'b0;
         r_overrun  <= 1'b0;
         r_rom_rd   <= 1'b0;
         r_rom_addr <= '0;
         r_v        <= '0;
         r_pend     <= 1'b0;
         r_pend_v   <= '0;
         r_busy     <= '0;
         r_acc_l    <= '0;
         r_ldata    <= '0;
`ifdef STEREO_PAN_EN
         r_acc_r    <= '0;
         r_rdata    <= '0;
`endif
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_ptr[i] <= '0;
            r_len[i] <= '0;
`ifdef STEREO_PAN_EN
            r_pan[i] <= '0;
`endif
         end
      end else begin
         r_pend   <= r_rom_rd;
         r_pend_v <= r_v;

         // Mix the sample read last cycle and step that voice forward.
         if (r_pend) begin
            r_acc_l <= r_acc_l + w_add_l;
`ifdef STEREO_PAN_EN
            r_acc_r <= r_acc_r + w_add_r;
`endif
            r_ptr[r_pend_v] <= r_ptr[r_pend_v] + AW'(1);
            r_len[r_pend_v] <= r_len[r_pend_v] - LW'(1);
            if (r_len[r_pend_v] == LW'(1)) r_busy[r_pend_v] <= 1'b0;
         end

         case (r_state)
            S_INIT: begin
               if (INIT_FINISH) begin
                  r_init  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_init  <= 1'b1;
               end
            end
            S_IDLE: begin
               if (data_over) begin
                  r_acc_l    <= '0;
`ifdef STEREO_PAN_EN
                  r_acc_r    <= '0;
`endif
                  r_v        <= '0;
                  r_rom_rd   <= r_busy[0];
                  r_rom_addr <= r_ptr[0];
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (r_v == V_W'(NUM_VOICES - 1)) begin
                  r_rom_rd <= 1'b0;
                  r_state  <= S_DRAIN;
               end else begin
                  r_v        <= w_v_nxt;
                  r_rom_rd   <= r_busy[w_v_nxt];
                  r_rom_addr <= r_ptr[w_v_nxt];
               end
            end
            S_DRAIN: r_state <= S_OUT;
            S_OUT: begin
               r_ldata <= sat16(r_acc_l);
`ifdef STEREO_PAN_EN
               r_rdata <= sat16(r_acc_r);
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_INIT;
         endcase

         // Triggers come last so a restart overrides a same-cycle advance.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_ready && trig[i] && (trig_len[i*LW +: LW] != '0)) begin
               r_ptr[i]  <= trig_addr[i*AW +: AW];
               r_len[i]  <= trig_len[i*LW +: LW];
               r_busy[i] <= 1'b1;
`ifdef STEREO_PAN_EN
               r_pan[i]  <= trig_pan[2*i +: 2];
`endif
            end
         end

         if (r_ready && data_over && (r_state != S_IDLE)) r_overrun <= 1'b1;
      end
   end

   assign INIT     = r_init;
   assign ready    = r_ready;
   assign overrun  = r_overrun;
   assign rom_rd   = r_rom_rd;
   assign rom_addr = r_rom_addr;
   assign busy     = r_busy;
   assign LDATA    = r_ldata;

endmodule

// File: doc/audio_voice_scheduler.md
Name: audio_voice_scheduler

Overview:
- Sequences the codec audio interface and feeds it samples from a shared sample ROM.
- After reset it drives the INIT handshake into the audio interface. On each data_over strobe it reads one sample per active sound-effect voice, mixes them with saturation and presents the result on LDATA/RDATA.
- It sits between the game logic (voice triggers), the sample ROM (single read port, shared) and the audio interface.

Parameters:
- NUM_VOICES, 4, number of independent sound-effect voices (1..8).
- AW, 16, sample ROM address width.
- LW, 16, voice length counter width (samples).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- INIT  out  1  init request to audio interface.
- INIT_FINISH  in  1  audio interface init done (level).
- data_over  in  1  one-cycle strobe: current LDATA/RDATA consumed, next sample needed.
- LDATA  out  16  left sample, signed two's complement.
- RDATA  out  16  right sample, signed two's complement.
- trig  in  NUM_VOICES  per-voice start pulse.
- trig_addr  in  NUM_VOICES*AW  per-voice start address; voice i uses slice [i*AW +: AW].
- trig_len  in  NUM_VOICES*LW  per-voice length in samples; voice i uses slice [i*LW +: LW].
- busy  out  NUM_VOICES  voice i is playing.
- rom_rd  out  1  ROM read enable.
- rom_addr  out  AW  ROM address.
- rom_data  in  16  ROM data, valid exactly one cycle after rom_rd.
- ready  out  1  codec initialised, mixing active.
- overrun  out  1  sticky flag: data_over arrived while not in S_IDLE.

Behaviour:
- Reset values: INIT=0, LDATA=0, RDATA=0, busy=0, rom_rd=0, rom_addr=0, ready=0, overrun=0. Voice pointers and lengths are 0. State is S_INIT.
- Reset asserted mid-operation aborts everything. After release the block re-runs the init sequence.
- S_INIT:
  - INIT=1 from the first clock after reset release, held until INIT_FINISH=1 is sampled.
  - On that edge: INIT=0, ready=1, go to S_IDLE.
  - data_over and trig are ignored in S_INIT.
- S_IDLE: on data_over=1, clear the accumulator, set voice index v=0, go to S_FETCH.
- S_FETCH: one cycle per voice, v = 0..NUM_VOICES-1.
  - If busy[v]: rom_rd=1, rom_addr=ptr[v]. Otherwise rom_rd=0.
  - The data arriving the following cycle is sign-extended to 16+clog2(NUM_VOICES) bits and added to the accumulator.
  - After v = NUM_VOICES-1, go to S_DRAIN (one cycle, absorbs the last read), then S_OUT.
- S_OUT:
  - Saturate the accumulator: >32767 gives 0x7FFF, <-32768 gives 0x8000.
  - Register the result to LDATA and RDATA; go to S_IDLE.
- Latency from data_over to LDATA/RDATA update is NUM_VOICES+3 cycles (default 7). With no voice busy the outputs become 0.
- Voice advance: after the read of voice v is accumulated, ptr[v]+=1 (wraps modulo 2^AW) and len[v]-=1. busy[v] clears in the cycle len reaches 0.
- Trigger:
  - trig[i]=1 with trig_len slice ≠ 0, while ready=1: load ptr[i] and len[i], busy[i]=1 next cycle.
  - A trigger on a busy voice restarts it.
  - trig_len slice = 0: ignored, busy unchanged.
- Trigger in the same cycle as voice i's pending advance: the trigger wins. The new ptr/len are loaded, the advance is discarded, and the sample already read is still mixed.
- data_over outside S_IDLE while ready=1: overrun set (sticky until Reset), strobe otherwise ignored.
- The ROM is only ever addressed by this block. At most one rom_rd per cycle.

Optional Feature:
- Macro STEREO_PAN_EN.
- Defined:
  - Extra input trig_pan, width 2*NUM_VOICES, latched with trig.
  - Per-voice pan values: 00 = both channels, 01 = left only, 10 = right only, 11 = both channels at half amplitude (arithmetic >>>1 before accumulate).
  - Two accumulators, each saturated independently to LDATA and RDATA.
- Undefined: no trig_pan port, one accumulator, LDATA==RDATA always.

Test Plan:
- Reset release, INIT_FINISH held 0 for 20 cycles then 1 → INIT=1 for exactly those cycles, drops the cycle after INIT_FINISH is sampled, ready=1; data_over during init gives no ROM reads.
- Voice 0 trig with addr=0x0100, len=3; ROM returns addr-derived data; 4 data_over strobes → rom_addr 0x0100, 0x0101, 0x0102 on successive frames; busy[0] clears after the 3rd frame; 4th frame LDATA=0.
- Voices 0..3 all returning 0x7000 → LDATA=RDATA=0x7FFF; all returning 0x9000 → 0x8000.
- Voice 1 at addr 0xFFFF, len=2 → second read at 0x0000 (wrap).
- Second data_over 3 cycles after the first → overrun=1, LDATA updates once at cycle 7; trig_len=0 on an idle voice → busy stays 0.
- STEREO_PAN_EN: voice 0 pan=01 with 0x1000, voice 1 pan=11 with 0x2000 → LDATA=0x2000, RDATA=0x1000; assert Reset mid-S_FETCH → all outputs 0, INIT reasserts.
